// File: rtl/traffic_phase_arbiter.sv
// traffic_phase_arbiter: demand-actuated, round-robin phase scheduler for a
// 4-way junction. Requests are latched per approach. Green length adapts
// between MIN_GREEN and MAX_GREEN, with gap-out. Unused approaches are skipped.
// Light encoding: GREEN=001, YELLOW=010, RED=100. Approach index: 0=N 1=S 2=E 3=W.
// Optional emergency preemption is compiled in when TRAFFIC_PREEMPT_EN is defined.
module traffic_phase_arbiter #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 16,
    parameter int GAP       = 2,
    parameter int YELLOW    = 4,
    parameter int ALL_RED   = 1,
    parameter int CW        = 5
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [3:0] sensor,
    input  logic       preempt_req,
    input  logic [1:0] preempt_dir,
    output logic [2:0] n_lights,
    output logic [2:0] s_lights,
    output logic [2:0] e_lights,
    output logic [2:0] w_lights,
    output logic [1:0] active_dir,
    output logic [3:0] pending,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_SAT = '1;
    localparam logic [CW-1:0] MIN_C   = CW'(MIN_GREEN);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_GREEN);
    localparam logic [CW-1:0] GAP_C   = CW'(GAP);
    localparam logic [CW-1:0] YEL_C   = CW'(YELLOW - 1);
    localparam logic [CW-1:0] AR_C    = CW'(ALL_RED - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;   // cycles left in YELLOW/ALLRED; 0 = last cycle
    logic [CW-1:0] gcnt_q, gcnt_d;     // green cycle number, 1 on the first green cycle
    logic [CW-1:0] gap_q, gap_d;       // own-sensor-low run up to the previous cycle
    logic [1:0]    active_q, active_d; // also serves as the last-served pointer
    logic [3:0]    pend_q, pend_d;
    logic [2:0]    n_q, s_q, e_q, w_q;
    logic [2:0]    n_d, s_d, e_d, w_d;

    logic [CW-1:0] gap_cur;
    logic          green_done;
    logic          other_pend;
    logic [3:0]    demand;
    logic [3:0]    green_mask;
    logic [1:0]    win;
    logic          have_win;
    logic          grant;

    function automatic logic [3:0] dir_mask(input logic [1:0] d);
        return 4'b0001 << d;
    endfunction

    function automatic logic [2:0] light_for(input state_t st, input logic [1:0] act,
                                             input logic [1:0] me);
        logic [2:0] l;
        l = 3'b100;
        if (act == me) begin
            if (st == S_GREEN)  l = 3'b001;
            if (st == S_YELLOW) l = 3'b010;
        end
        return l;
    endfunction

    // Next-state logic: phase sequencing, round-robin arbitration and request latching.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        gcnt_d     = gcnt_q;
        gap_d      = gap_q;
        active_d   = active_q;
        grant      = 1'b0;
        win        = active_q;
        have_win   = 1'b0;

        // Gap including the current cycle's sensor sample.
        gap_cur    = sensor[active_q] ? '0 : ((gap_q == CNT_SAT) ? gap_q : gap_q + 1'b1);
        other_pend = |(pend_q & ~dir_mask(active_q));
        green_done = (gcnt_q >= MIN_C) &&
                     ((gap_cur >= GAP_C) || ((gcnt_q >= MAX_C) && other_pend));

        // First requester after the last-served approach, wrapping to itself last.
        demand = pend_q | sensor;
        for (int k = 1; k <= 4; k++) begin
            if (!have_win && demand[active_q + 2'(k)]) begin
                win      = active_q + 2'(k);
                have_win = 1'b1;
            end
        end

`ifdef TRAFFIC_PREEMPT_EN
        // Preemption: cut a conflicting green at once, hold a matching one,
        // and force the next grant to the preempted approach.
        if (preempt_req) begin
            green_done = (preempt_dir != active_q);
            win        = preempt_dir;
            have_win   = 1'b1;
        end
`endif

        case (state_q)
            S_ALLRED: begin
                if (timer_q == '0) begin
                    if (have_win) begin
                        state_d  = S_GREEN;
                        active_d = win;
                        gcnt_d   = CW'(1);
                        gap_d    = '0;
                        grant    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_GREEN: begin
                gcnt_d = (gcnt_q == CNT_SAT) ? gcnt_q : gcnt_q + 1'b1;
                gap_d  = gap_cur;
                if (green_done) begin
                    state_d = S_YELLOW;
                    timer_d = YEL_C;
                end
            end
            S_YELLOW: begin
                if (timer_q == '0) begin
                    state_d = S_ALLRED;
                    timer_d = AR_C;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_ALLRED;
                timer_d = '0;
            end
        endcase

        // The green approach never latches its own sensor; grant clears win over set.
        green_mask = (state_q == S_GREEN) ? dir_mask(active_q) : 4'b0000;
        pend_d     = pend_q | (sensor & ~green_mask);
        if (grant) pend_d = pend_d & ~dir_mask(win);

        n_d = light_for(state_d, active_d, 2'd0);
        s_d = light_for(state_d, active_d, 2'd1);
        e_d = light_for(state_d, active_d, 2'd2);
        w_d = light_for(state_d, active_d, 2'd3);
    end

`ifndef TRAFFIC_PREEMPT_EN
    logic unused_preempt;
    assign unused_preempt = ^{preempt_req, preempt_dir};
`endif

    // State and registered outputs; reset leaves ALLRED expired with N first in line.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q  <= S_ALLRED;
            timer_q  <= '0;
            gcnt_q   <= '0;
            gap_q    <= '0;
            active_q <= 2'd3;
            pend_q   <= 4'b0000;
            n_q      <= 3'b100;
            s_q      <= 3'b100;
            e_q      <= 3'b100;
            w_q      <= 3'b100;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            gcnt_q   <= gcnt_d;
            gap_q    <= gap_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            n_q      <= n_d;
            s_q      <= s_d;
            e_q      <= e_d;
            w_q      <= w_d;
        end
    end

    assign n_lights    = n_q;
    assign s_lights    = s_q;
    assign e_lights    = e_q;
    assign w_lights    = w_q;
    assign active_dir  = active_q;
    assign pending     = pend_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// tb_traffic_phase_arbiter: directed bench for traffic_phase_arbiter.
// Expected per-cycle words {active_dir, pending, n, s, e, w} are queued when
// stimulus is applied and compared on the falling edge, one per cycle.
module tb_traffic_phase_arbiter;

    logic       clk = 1'b0;
    logic       rst_a;
    logic [3:0] sensor;
    logic       preempt_req;
    logic [1:0] preempt_dir;
    logic [2:0] n_lights, s_lights, e_lights, w_lights;
    logic [1:0] active_dir;
    logic [3:0] pending;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [17:0] exp_q[$];

    traffic_phase_arbiter dut (
        .clk         (clk),
        .rst_a       (rst_a),
        .sensor      (sensor),
        .preempt_req (preempt_req),
        .preempt_dir (preempt_dir),
        .n_lights    (n_lights),
        .s_lights    (s_lights),
        .e_lights    (e_lights),
        .w_lights    (w_lights),
        .active_dir  (active_dir),
        .pending     (pending),
        .dbg_state_o (dbg_state)
    );

    // Clock: 10 time units, rising edges at 5, 15, ...
    always #5 clk = ~clk;

    // Expected word: col 0 = all red, 1 = dir green, 2 = dir yellow.
    function automatic logic [17:0] mk(input logic [1:0] dir, input int col, input logic [3:0] pend);
        logic [2:0] l [4];
        for (int i = 0; i < 4; i++) l[i] = 3'b100;
        if (col == 1) l[dir] = 3'b001;
        if (col == 2) l[dir] = 3'b010;
        return {dir, pend, l[0], l[1], l[2], l[3]};
    endfunction

    task automatic push(input logic [1:0] dir, input int col, input logic [3:0] pend, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(dir, col, pend));
    endtask

    task automatic check_one(input string tag);
        logic [17:0] obs;
        logic [17:0] exp;
        obs = {active_dir, pending, n_lights, s_lights, e_lights, w_lights};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL %s: observed %h with no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // Compare n consecutive cycles, starting at the current falling edge.
    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_one(tag);
            @(negedge clk);
        end
    endtask

    // Reset pulse; returns at a falling edge with reset released and inputs idle.
    task automatic do_reset();
        rst_a       = 1'b0;
        sensor      = 4'b0000;
        preempt_req = 1'b0;
        preempt_dir = 2'd0;
        @(negedge clk);
        push(2'd3, 0, 4'b0000, 1);
        run("reset", 1);
        rst_a = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Single short request from idle: min green, yellow, all-red, idle.
        do_reset();
        sensor = 4'b0001;
        @(negedge clk);
        sensor = 4'b0000;
        push(2'd0, 1, 4'b0000, 4);
        push(2'd0, 2, 4'b0000, 4);
        push(2'd0, 0, 4'b0000, 3);
        run("single_req", 11);

        // Asynchronous reset between edges in the middle of a green.
        sensor = 4'b0001;
        @(negedge clk);
        sensor = 4'b0000;
        push(2'd0, 1, 4'b0000, 2);
        run("pre_async", 2);
        #2;
        rst_a = 1'b0;
        #1;
        push(2'd3, 0, 4'b0000, 1);
        check_one("async_reset");
        @(negedge clk);
        rst_a = 1'b1;
        push(2'd3, 0, 4'b0000, 3);
        run("post_reset_idle", 3);
        sensor = 4'b0100;
        @(negedge clk);
        sensor = 4'b0000;
        push(2'd2, 1, 4'b0000, 1);
        run("post_reset_grant", 1);

        // Three held requests: N, E, W, N each for MAX_GREEN; S skipped.
        do_reset();
        sensor = 4'b1101;
        @(negedge clk);
        push(2'd0, 1, 4'b1100, 16);
        push(2'd0, 2, 4'b1100, 1);
        push(2'd0, 2, 4'b1101, 3);
        push(2'd0, 0, 4'b1101, 1);
        push(2'd2, 1, 4'b1001, 16);
        push(2'd2, 2, 4'b1001, 1);
        push(2'd2, 2, 4'b1101, 3);
        push(2'd2, 0, 4'b1101, 1);
        push(2'd3, 1, 4'b0101, 16);
        push(2'd3, 2, 4'b0101, 1);
        push(2'd3, 2, 4'b1101, 3);
        push(2'd3, 0, 4'b1101, 1);
        push(2'd0, 1, 4'b1100, 16);
        run("round_robin", 79);

        // Lone held request rests in green past MAX_GREEN until a competitor appears.
        do_reset();
        sensor = 4'b0010;
`ifndef TRAFFIC_PREEMPT_EN
        preempt_req = 1'b1;
        preempt_dir = 2'd3;
`endif
        @(negedge clk);
        push(2'd1, 1, 4'b0000, 40);
        run("rest_green", 39);
        sensor = 4'b0110;
        push(2'd1, 1, 4'b0100, 1);
        push(2'd1, 2, 4'b0100, 1);
        push(2'd1, 2, 4'b0110, 3);
        push(2'd1, 0, 4'b0110, 1);
        push(2'd2, 1, 4'b0010, 2);
        run("competitor", 9);
        preempt_req = 1'b0;

        // Pulsed competitor during a held green: green runs to MAX_GREEN, then W, then N.
        do_reset();
        sensor = 4'b0001;
        @(negedge clk);
        push(2'd0, 1, 4'b0000, 2);
        run("pulse_pre", 1);
        sensor = 4'b1001;
        run("pulse_pre", 1);
        sensor = 4'b0001;
        push(2'd0, 1, 4'b1000, 14);
        push(2'd0, 2, 4'b1000, 1);
        push(2'd0, 2, 4'b1001, 3);
        push(2'd0, 0, 4'b1001, 1);
        push(2'd3, 1, 4'b0001, 4);
        push(2'd3, 2, 4'b0001, 4);
        push(2'd3, 0, 4'b0001, 1);
        push(2'd0, 1, 4'b0000, 1);
        run("pulse_max", 29);

`ifdef TRAFFIC_PREEMPT_EN
        // Preemption: E cut at once, W granted and held past MAX_GREEN, released to E.
        do_reset();
        sensor = 4'b0100;
        @(negedge clk);
        preempt_req = 1'b1;
        preempt_dir = 2'd3;
        push(2'd2, 1, 4'b0000, 1);
        push(2'd2, 2, 4'b0000, 1);
        push(2'd2, 2, 4'b0100, 3);
        push(2'd2, 0, 4'b0100, 1);
        push(2'd3, 1, 4'b0100, 20);
        run("preempt_hold", 25);
        preempt_req = 1'b0;
        push(2'd3, 2, 4'b0100, 4);
        push(2'd3, 0, 4'b0100, 1);
        push(2'd2, 1, 4'b0000, 1);
        run("preempt_release", 7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
